// File: rtl/tgate_bus_switch.sv
// rtl/tgate_bus_switch.sv - N-channel transmission-gate bus switch with break-before-make control
module tgate_bus_switch #(
  parameter  int WIDTH       = 8,
  parameter  int CHANNELS    = 4,
  parameter  int DEAD_CYCLES = 2,
  localparam int SELW        = $clog2(CHANNELS),
  localparam int CW          = $clog2(DEAD_CYCLES + 1)
) (
  input  logic                      clk,
  input  logic                      clrn,
  input  logic                      req_valid,
  input  logic                      req_en,
  input  logic [SELW-1:0]           req_sel,
  output logic                      req_ready,
  output logic                      req_err,
  input  logic [CHANNELS*WIDTH-1:0] ch_in,
  output tri   [WIDTH-1:0]          bus,
  output logic [CHANNELS-1:0]       n_gate,
  output logic [CHANNELS-1:0]       p_gate,
  output logic                      bus_on,
  output logic [SELW-1:0]           cur_sel
);

  typedef enum logic [1:0] {
    ST_OPEN = 2'd0,
    ST_ON   = 2'd1,
    ST_DEAD = 2'd2
  } state_t;

  localparam logic [CHANNELS-1:0] GATE_ONE = {{(CHANNELS-1){1'b0}}, 1'b1};

  // One bit per encodable select value; set only for channels that exist.
  function automatic logic [(1<<SELW)-1:0] valid_mask_f();
    logic [(1<<SELW)-1:0] m;
    m = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      m[i] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [(1<<SELW)-1:0] VALID_MASK = valid_mask_f();

  state_t              state_q;
  logic [CHANNELS-1:0] n_gate_q;
  logic [SELW-1:0]     cur_sel_q;
  logic [SELW-1:0]     pend_sel_q;
  logic                pend_q;
  logic [CW-1:0]       cnt_q;
  logic                req_err_q;
  logic                sel_ok;
  logic [WIDTH-1:0]    pass_data;

  assign sel_ok    = VALID_MASK[req_sel];
  assign req_ready = (state_q != ST_DEAD);
  assign req_err   = req_err_q;
  assign n_gate    = n_gate_q;
  assign p_gate    = ~n_gate_q;
  assign bus_on    = |n_gate_q;
  assign cur_sel   = cur_sel_q;

  // Controller: gates only ever change here, and every break passes through DEAD before any make.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q    <= ST_OPEN;
      n_gate_q   <= '0;
      cur_sel_q  <= '0;
      pend_sel_q <= '0;
      pend_q     <= 1'b0;
      cnt_q      <= '0;
      req_err_q  <= 1'b0;
    end else begin
      req_err_q <= 1'b0;
      case (state_q)
        ST_OPEN: begin
          if (req_valid && req_en) begin
            if (!sel_ok) begin
              req_err_q <= 1'b1;
            end else begin
              n_gate_q  <= GATE_ONE << req_sel;
              cur_sel_q <= req_sel;
              state_q   <= ST_ON;
            end
          end
        end
        ST_ON: begin
          if (req_valid) begin
            if (!req_en) begin
              n_gate_q  <= '0;
              cur_sel_q <= '0;
              pend_q    <= 1'b0;
              cnt_q     <= CW'(DEAD_CYCLES);
              state_q   <= ST_DEAD;
            end else if (!sel_ok) begin
              req_err_q <= 1'b1;
            end else if (req_sel != cur_sel_q) begin
              n_gate_q   <= '0;
              cur_sel_q  <= '0;
              pend_q     <= 1'b1;
              pend_sel_q <= req_sel;
              cnt_q      <= CW'(DEAD_CYCLES);
              state_q    <= ST_DEAD;
            end
          end
        end
        ST_DEAD: begin
          if (cnt_q == '0) begin
            if (pend_q) begin
              n_gate_q  <= GATE_ONE << pend_sel_q;
              cur_sel_q <= pend_sel_q;
              state_q   <= ST_ON;
            end else begin
              state_q <= ST_OPEN;
            end
            pend_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          state_q  <= ST_OPEN;
          n_gate_q <= '0;
        end
      endcase
    end
  end

  // Transmission-gate network: a channel conducts only with its nmos on and its pmos gate low.
  always_comb begin
    pass_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (n_gate_q[i] && !p_gate[i]) begin
        pass_data = pass_data | ch_in[i*WIDTH +: WIDTH];
      end
    end
  end

  assign bus = bus_on ? pass_data : {WIDTH{1'bz}};

endmodule

// File: tb/tb_tgate_bus_switch.sv
// tb/tb_tgate_bus_switch.sv - self-checking bench for tgate_bus_switch
module tb_tgate_bus_switch;

  logic        clk;
  logic        clrn;
  logic        req_valid, req_en;
  logic [1:0]  req_sel;
  logic        req_ready, req_err, bus_on;
  logic [31:0] ch_in;
  wire  [7:0]  bus;
  logic [3:0]  n_gate, p_gate;
  logic [1:0]  cur_sel;

  logic        r3_valid, r3_en;
  logic [1:0]  r3_sel;
  logic        r3_ready, r3_err, r3_on;
  logic [23:0] ch_in3;
  wire  [7:0]  bus3;
  logic [2:0]  n3, p3;
  logic [1:0]  cur3;

  int checks = 0;
  int errors = 0;

  logic [7:0] chv [4];

  tgate_bus_switch #(.WIDTH(8), .CHANNELS(4), .DEAD_CYCLES(2)) dut (
    .clk(clk), .clrn(clrn), .req_valid(req_valid), .req_en(req_en), .req_sel(req_sel),
    .req_ready(req_ready), .req_err(req_err), .ch_in(ch_in), .bus(bus),
    .n_gate(n_gate), .p_gate(p_gate), .bus_on(bus_on), .cur_sel(cur_sel)
  );

  tgate_bus_switch #(.WIDTH(8), .CHANNELS(3), .DEAD_CYCLES(2)) dut3 (
    .clk(clk), .clrn(clrn), .req_valid(r3_valid), .req_en(r3_en), .req_sel(r3_sel),
    .req_ready(r3_ready), .req_err(r3_err), .ch_in(ch_in3), .bus(bus3),
    .n_gate(n3), .p_gate(p3), .bus_on(r3_on), .cur_sel(cur3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [7:0] exp_bus(input logic [3:0] ng);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 4; i++) if (ng[i]) r = chv[i];
    return r;
  endfunction

  // Invariant monitor: one-hot-or-zero gates, complementary pmos, and dead time before every re-make.
  logic had_gate;
  int   off_run;
  always @(negedge clk) begin
    if (!clrn) begin
      had_gate = 1'b0;
      off_run  = 0;
    end else begin
      chk("inv_popcount", 32'($countones(n_gate) <= 1), 32'd1);
      chk("inv_pgate", {28'd0, p_gate}, {28'd0, ~n_gate});
      chk("inv3_popcount", 32'($countones(n3) <= 1), 32'd1);
      if (n_gate == 4'b0000) begin
        off_run++;
      end else begin
        if (had_gate && off_run > 0) chk("inv_dead_time", 32'(off_run >= 2), 32'd1);
        had_gate = 1'b1;
        off_run  = 0;
      end
    end
  end

  typedef struct {
    logic       v;
    logic       en;
    logic [1:0] sel;
    logic [3:0] ng;
    logic       rdy;
    logic [1:0] cur;
  } vec_t;

  vec_t vecs [21];

  task automatic check_state(input string nm, input logic [3:0] ng, input logic rdy, input logic [1:0] cur);
    chk({nm, "_ngate"}, {28'd0, n_gate}, {28'd0, ng});
    chk({nm, "_pgate"}, {28'd0, p_gate}, {28'd0, ~ng});
    chk({nm, "_ready"}, {31'd0, req_ready}, {31'd0, rdy});
    chk({nm, "_bus_on"}, {31'd0, bus_on}, {31'd0, |ng});
    chk({nm, "_cur_sel"}, {30'd0, cur_sel}, {30'd0, cur});
    chk({nm, "_err"}, {31'd0, req_err}, 32'd0);
    if (|ng) chk({nm, "_bus"}, {24'd0, bus}, {24'd0, exp_bus(ng)});
  endtask

  task automatic drive(input logic v, input logic en, input logic [1:0] sel);
    req_valid = v;
    req_en    = en;
    req_sel   = sel;
  endtask

  // Reset pulled asynchronously during the high phase; held across one low phase.
  task automatic async_reset(input string nm);
    @(posedge clk);
    #2;
    clrn = 1'b0;
    #1;
    chk({nm, "_ngate"}, {28'd0, n_gate}, 32'd0);
    chk({nm, "_pgate"}, {28'd0, p_gate}, 32'hF);
    chk({nm, "_bus_on"}, {31'd0, bus_on}, 32'd0);
    chk({nm, "_cur_sel"}, {30'd0, cur_sel}, 32'd0);
    chk({nm, "_ready"}, {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    #1;
    clrn = 1'b1;
  endtask

  initial begin
    chv[0] = 8'h11; chv[1] = 8'h3C; chv[2] = 8'hA5; chv[3] = 8'h7E;
    ch_in  = {chv[3], chv[2], chv[1], chv[0]};
    ch_in3 = 24'hC3_5A_96;
    drive(1'b0, 1'b0, 2'd0);
    r3_valid = 1'b0; r3_en = 1'b0; r3_sel = 2'd0;

    //            v     en    sel    n_gate    rdy   cur
    vecs[0]  = '{1'b1, 1'b1, 2'd2, 4'b0100, 1'b1, 2'd2};
    vecs[1]  = '{1'b0, 1'b0, 2'd0, 4'b0100, 1'b1, 2'd2};
    vecs[2]  = '{1'b1, 1'b1, 2'd1, 4'b0000, 1'b0, 2'd0};
    vecs[3]  = '{1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0};
    vecs[4]  = '{1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0};
    vecs[5]  = '{1'b0, 1'b0, 2'd0, 4'b0010, 1'b1, 2'd1};
    vecs[6]  = '{1'b1, 1'b1, 2'd1, 4'b0010, 1'b1, 2'd1};
    vecs[7]  = '{1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0};
    vecs[8]  = '{1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0};
    vecs[9]  = '{1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0};
    vecs[10] = '{1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd0};
    vecs[11] = '{1'b1, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd0};
    vecs[12] = '{1'b1, 1'b1, 2'd0, 4'b0001, 1'b1, 2'd0};
    vecs[13] = '{1'b1, 1'b1, 2'd2, 4'b0000, 1'b0, 2'd0};
    vecs[14] = '{1'b1, 1'b1, 2'd3, 4'b0000, 1'b0, 2'd0};
    vecs[15] = '{1'b1, 1'b1, 2'd3, 4'b0000, 1'b0, 2'd0};
    vecs[16] = '{1'b1, 1'b1, 2'd3, 4'b0100, 1'b1, 2'd2};
    vecs[17] = '{1'b1, 1'b1, 2'd3, 4'b0000, 1'b0, 2'd0};
    vecs[18] = '{1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0};
    vecs[19] = '{1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0};
    vecs[20] = '{1'b0, 1'b0, 2'd0, 4'b1000, 1'b1, 2'd3};

    clrn = 1'b0;
    repeat (2) @(negedge clk);
    check_state("reset", 4'b0000, 1'b1, 2'd0);
    clrn = 1'b1;
    @(negedge clk);
    check_state("post_reset", 4'b0000, 1'b1, 2'd0);

    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].v, vecs[i].en, vecs[i].sel);
      step();
      check_state($sformatf("vec%0d", i), vecs[i].ng, vecs[i].rdy, vecs[i].cur);
    end

    // Reset while ON ch3, then one-cycle connect to ch0.
    drive(1'b0, 1'b0, 2'd0);
    async_reset("rst_on");
    drive(1'b1, 1'b1, 2'd0);
    step();
    check_state("rst_on_conn0", 4'b0001, 1'b1, 2'd0);

    // Reset in the middle of a dead period.
    drive(1'b1, 1'b1, 2'd1);
    step();
    drive(1'b0, 1'b0, 2'd0);
    step();
    check_state("mid_dead", 4'b0000, 1'b0, 2'd0);
    async_reset("rst_dead");
    drive(1'b1, 1'b1, 2'd0);
    step();
    check_state("rst_dead_conn0", 4'b0001, 1'b1, 2'd0);
    drive(1'b0, 1'b0, 2'd0);

    // Three-channel build: select 3 is out of range.
    r3_valid = 1'b1; r3_en = 1'b1; r3_sel = 2'd3;
    step();
    chk("c3_open_err", {31'd0, r3_err}, 32'd1);
    chk("c3_open_gates", {29'd0, n3}, 32'd0);
    r3_valid = 1'b0;
    step();
    chk("c3_err_clear", {31'd0, r3_err}, 32'd0);
    r3_valid = 1'b1; r3_sel = 2'd1;
    step();
    chk("c3_conn1", {29'd0, n3}, 32'b010);
    chk("c3_bus1", {24'd0, bus3}, 32'h5A);
    r3_sel = 2'd3;
    step();
    chk("c3_on_err", {31'd0, r3_err}, 32'd1);
    chk("c3_on_gates", {29'd0, n3}, 32'b010);
    chk("c3_on_ready", {31'd0, r3_ready}, 32'd1);
    chk("c3_on_cur", {30'd0, cur3}, 32'd1);
    r3_valid = 1'b0;
    step();
    chk("c3_on_err_clear", {31'd0, r3_err}, 32'd0);

    // Random request stress; the invariant monitor does the checking.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)));
      r3_valid = 1'($urandom_range(0, 1));
      r3_en    = 1'($urandom_range(0, 3) != 0);
      r3_sel   = 2'($urandom_range(0, 3));
      step();
      if (bus_on) chk("stress_bus", {24'd0, bus}, {24'd0, chv[cur_sel]});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
